line_raster_stepper: RTL and testbench

//  Sequential Bresenham iterator placed directly downstream of the line-drawing precompute stage.
//  Per line, it accepts one parameter set: x0, x1, deltax, deltay, y0, ystep, steep.
//  It emits one pixel coordinate per cycle into the fragment/framebuffer write path, with a valid/ready handshake.
//  The steep swap is undone at the output, so every coordinate is in screen space.

---
 rtl/line_pkg.sv | 14 +
 rtl/bresenham_err_step.sv | 29 ++
 rtl/line_raster_stepper.sv | 129 ++++++++++++
 tb/tb_line_raster_stepper.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/line_pkg.sv
// Shared widths, y-step encodings and FSM state type for the line raster path.
package line_pkg;

  localparam int unsigned LINE_W = 13;

  localparam logic [LINE_W-1:0] YSTEP_POS = 13'h0001;
  localparam logic [LINE_W-1:0] YSTEP_NEG = 13'h1FFF;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_e;

endpackage

// File: rtl/bresenham_err_step.sv
// One Bresenham error update: decide whether y advances and produce the next error term.
module bresenham_err_step
  import line_pkg::*;
#(
  parameter int unsigned WIDTH = LINE_W
) (
  input  logic signed [WIDTH:0]   err,
  input  logic        [WIDTH-1:0] dx,
  input  logic        [WIDTH-1:0] dy,
  input  logic        [WIDTH-1:0] y_cur,
  input  logic        [WIDTH-1:0] ystep,
  output logic signed [WIDTH:0]   err_next,
  output logic        [WIDTH-1:0] y_next
);

  logic signed [WIDTH:0] err_sub;

  always_comb begin
    err_sub  = err - $signed({1'b0, dy});
    err_next = err_sub;
    y_next   = y_cur;
    // Negative error means the ideal line crossed the half-pixel: step y and re-bias.
    if (err_sub[WIDTH]) begin
      y_next   = y_cur + ystep;
      err_next = err_sub + $signed({1'b0, dx});
    end
  end

endmodule

// File: rtl/line_raster_stepper.sv
// Sequential Bresenham iterator: takes one precomputed line and emits one screen-space
// pixel per accepted handshake, undoing the steep axis swap at the output.
module line_raster_stepper
  import line_pkg::*;
#(
  parameter int unsigned WIDTH = LINE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x0,
  input  logic [WIDTH-1:0] in_x1,
  input  logic [WIDTH-1:0] in_deltax,
  input  logic [WIDTH-1:0] in_deltay,
  input  logic [WIDTH-1:0] in_y0,
  input  logic [WIDTH-1:0] in_ystep,
  input  logic             in_steep,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_x,
  output logic [WIDTH-1:0] out_y,
  output logic             out_last,
  output logic             busy
);

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      x_cur_q, x_cur_d;
  logic [WIDTH-1:0]      y_cur_q, y_cur_d;
  logic [WIDTH-1:0]      x_end_q, x_end_d;
  logic [WIDTH-1:0]      dx_q, dx_d;
  logic [WIDTH-1:0]      dy_q, dy_d;
  logic [WIDTH-1:0]      ystep_q, ystep_d;
  logic                  steep_q, steep_d;
  logic signed [WIDTH:0] err_q, err_d;

  logic signed [WIDTH:0] err_next;
  logic [WIDTH-1:0]      y_next;
  logic                  at_end;

  bresenham_err_step #(
    .WIDTH (WIDTH)
  ) u_err_step (
    .err      (err_q),
    .dx       (dx_q),
    .dy       (dy_q),
    .y_cur    (y_cur_q),
    .ystep    (ystep_q),
    .err_next (err_next),
    .y_next   (y_next)
  );

  assign at_end = (x_cur_q == x_end_q);

  always_comb begin
    state_d = state_q;
    x_cur_d = x_cur_q;
    y_cur_d = y_cur_q;
    x_end_d = x_end_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    ystep_d = ystep_q;
    steep_d = steep_q;
    err_d   = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_RUN;
          x_cur_d = in_x0;
          y_cur_d = in_y0;
          x_end_d = in_x1;
          dx_d    = in_deltax;
          dy_d    = in_deltay;
          ystep_d = in_ystep;
          steep_d = in_steep;
          // deltax is non-negative, so the half is a plain right shift with zero fill.
          err_d   = $signed({2'b00, in_deltax[WIDTH-1:1]});
        end
      end
      ST_RUN: begin
        if (out_ready) begin
          if (at_end) begin
            state_d = ST_IDLE;
          end else begin
            x_cur_d = x_cur_q + WIDTH'(1);
            y_cur_d = y_next;
            err_d   = err_next;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      x_cur_q <= '0;
      y_cur_q <= '0;
      x_end_q <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      ystep_q <= '0;
      steep_q <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      x_cur_q <= x_cur_d;
      y_cur_q <= y_cur_d;
      x_end_q <= x_end_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      ystep_q <= ystep_d;
      steep_q <= steep_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    out_valid = (state_q == ST_RUN);
    busy      = (state_q == ST_RUN);
    in_ready  = (state_q == ST_IDLE);
    out_last  = out_valid && at_end;
    out_x     = steep_q ? y_cur_q : x_cur_q;
    out_y     = steep_q ? x_cur_q : y_cur_q;
  end

endmodule

// File: tb/tb_line_raster_stepper.sv
// Directed bench for line_raster_stepper: hand-computed pixel sequences, stalls, resets.
module tb_line_raster_stepper;

  localparam int unsigned W = 13;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_x0, in_x1, in_deltax, in_deltay, in_y0, in_ystep;
  logic         in_steep;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_x, out_y;
  logic         out_last;
  logic         busy;

  int checks = 0;
  int errors = 0;

  line_raster_stepper #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x0     (in_x0),
    .in_x1     (in_x1),
    .in_deltax (in_deltax),
    .in_deltay (in_deltay),
    .in_y0     (in_y0),
    .in_ystep  (in_ystep),
    .in_steep  (in_steep),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_line(input logic [W-1:0] x0, input logic [W-1:0] x1,
                          input logic [W-1:0] dx, input logic [W-1:0] dy,
                          input logic [W-1:0] y0, input logic [W-1:0] ys,
                          input logic st);
    in_x0     = x0;
    in_x1     = x1;
    in_deltax = dx;
    in_deltay = dy;
    in_y0     = y0;
    in_ystep  = ys;
    in_steep  = st;
  endtask

  task automatic expect_pix(input string tag, input int x, input int y, input logic last);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".x"}, 32'(out_x), 32'(x));
    chk({tag, ".y"}, 32'(out_y), 32'(y));
    chk({tag, ".last"}, 32'(out_last), 32'(last));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd0);
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, ".valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, ".last"}, 32'(out_last), 32'd0);
  endtask

  // Present a parameter set for one edge; afterwards the first pixel should be visible.
  task automatic accept();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    set_line('0, '0, '0, '0, '0, '0, 1'b0);
    step();
    step();
    expect_idle("reset");
    rst_n = 1'b1;
    step();
    expect_idle("post_reset");

    // Test 1: non-steep, shallow positive slope.
    set_line(13'd0, 13'd4, 13'd4, 13'd2, 13'd0, 13'h0001, 1'b0);
    accept();
    chk("t1.busy", 32'(busy), 32'd1);
    expect_pix("t1.p0", 0, 0, 1'b0); step();
    expect_pix("t1.p1", 1, 0, 1'b0); step();
    expect_pix("t1.p2", 2, 1, 1'b0); step();
    expect_pix("t1.p3", 3, 1, 1'b0); step();
    expect_pix("t1.p4", 4, 2, 1'b1); step();
    expect_idle("t1.end");

    // Test 2: steep line, coordinates swapped back at the output.
    set_line(13'd0, 13'd3, 13'd3, 13'd1, 13'd0, 13'h0001, 1'b1);
    accept();
    expect_pix("t2.p0", 0, 0, 1'b0); step();
    expect_pix("t2.p1", 0, 1, 1'b0); step();
    expect_pix("t2.p2", 1, 2, 1'b0); step();
    expect_pix("t2.p3", 1, 3, 1'b1); step();
    expect_idle("t2.end");

    // Test 3: y decreasing.
    set_line(13'd0, 13'd2, 13'd2, 13'd2, 13'd2, 13'h1FFF, 1'b0);
    accept();
    expect_pix("t3.p0", 0, 2, 1'b0); step();
    expect_pix("t3.p1", 1, 1, 1'b0); step();
    expect_pix("t3.p2", 2, 0, 1'b1); step();
    expect_idle("t3.end");

    // Test 4: stall on pixel 2 with a competing parameter set held on the input.
    set_line(13'd0, 13'd4, 13'd4, 13'd2, 13'd0, 13'h0001, 1'b0);
    accept();
    expect_pix("t4.p0", 0, 0, 1'b0); step();
    expect_pix("t4.p1", 1, 0, 1'b0);
    out_ready = 1'b0;
    set_line(13'd100, 13'd200, 13'd100, 13'd9, 13'd50, 13'h0001, 1'b1);
    in_valid = 1'b1;
    step(); expect_pix("t4.stall0", 1, 0, 1'b0); chk("t4.busy0", 32'(busy), 32'd1);
    step(); expect_pix("t4.stall1", 1, 0, 1'b0);
    step(); expect_pix("t4.stall2", 1, 0, 1'b0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step(); expect_pix("t4.p2", 2, 1, 1'b0); step();
    expect_pix("t4.p3", 3, 1, 1'b0); step();
    expect_pix("t4.p4", 4, 2, 1'b1); step();
    expect_idle("t4.end");

    // Test 5: single-pixel line, then a second set waiting on the input.
    set_line(13'd7, 13'd7, 13'd0, 13'd0, 13'd5, 13'h0001, 1'b0);
    accept();
    expect_pix("t5.single", 7, 5, 1'b1);
    set_line(13'd0, 13'd2, 13'd2, 13'd2, 13'd2, 13'h1FFF, 1'b0);
    in_valid = 1'b1;
    step();
    expect_idle("t5.bubble");
    step();
    in_valid = 1'b0;
    expect_pix("t5.b2b.p0", 0, 2, 1'b0); step();
    expect_pix("t5.b2b.p1", 1, 1, 1'b0); step();
    expect_pix("t5.b2b.p2", 2, 0, 1'b1); step();
    expect_idle("t5.end");

    // Test 6: reset during pixel 3, then a fresh line.
    set_line(13'd0, 13'd4, 13'd4, 13'd2, 13'd0, 13'h0001, 1'b0);
    accept();
    expect_pix("t6.p0", 0, 0, 1'b0); step();
    expect_pix("t6.p1", 1, 0, 1'b0); step();
    expect_pix("t6.p2", 2, 1, 1'b0);
    rst_n = 1'b0;
    step();
    expect_idle("t6.reset");
    rst_n = 1'b1;
    set_line(13'd0, 13'd3, 13'd3, 13'd1, 13'd0, 13'h0001, 1'b1);
    accept();
    expect_pix("t6.new.p0", 0, 0, 1'b0); step();
    expect_pix("t6.new.p1", 0, 1, 1'b0); step();
    expect_pix("t6.new.p2", 1, 2, 1'b0); step();
    expect_pix("t6.new.p3", 1, 3, 1'b1); step();
    expect_idle("t6.end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
